// File: rtl/pic_pkg.sv
// Shared definitions for the PIC-side interrupt-acknowledge logic: sequencer states,
// CALL opcode and pulse counts for the two acknowledge modes.
package pic_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StGap   = 2'd2,
        StHold  = 2'd3
    } inta_state_e;

    localparam logic [7:0]  CALL_OPCODE     = 8'hCD;
    localparam int unsigned NUM_PULSES_8086 = 2;
    localparam int unsigned NUM_PULSES_8080 = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous PIC-side inputs.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge initiator: issues the INTA pulse train and captures the vector.
// Define INTA_MODE_8080_EN for the 3-pulse 8080 CALL sequence (default: 2-pulse 8086 mode).
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned INTA_LOW_CYCLES = 2,
    parameter int unsigned INTA_GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        intr,
    input  logic        int_en,
    input  logic [7:0]  data_in,
    output logic        inta_n,
    output logic        busy,
    output logic        vector_valid,
    output logic [7:0]  vector,
    input  logic        vector_ack,
    output logic [15:0] call_addr
);

`ifdef INTA_MODE_8080_EN
    localparam int unsigned NUM_PULSES = NUM_PULSES_8080;
`else
    localparam int unsigned NUM_PULSES = NUM_PULSES_8086;
`endif

    localparam int unsigned WMAX = max_u(INTA_LOW_CYCLES, INTA_GAP_CYCLES);
    localparam int unsigned WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

    localparam logic [WW-1:0] LOW_LAST   = WW'(INTA_LOW_CYCLES - 1);
    localparam logic [WW-1:0] GAP_LAST   = WW'(INTA_GAP_CYCLES - 1);
    localparam logic [1:0]    LAST_PULSE = 2'(NUM_PULSES - 1);

    inta_state_e   state_q, state_d;
    logic [1:0]    pcnt_q, pcnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          inta_n_q, inta_n_d;
    logic          valid_q, valid_d;
    logic [7:0]    vector_q, vector_d;
    logic          intr_s;

`ifdef INTA_MODE_8080_EN
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    addr_hi_q, addr_hi_d;
`endif

    sync_2ff u_intr_sync (
        .clk   (clk),
        .reset (reset),
        .d     (intr),
        .q     (intr_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pcnt_q    <= 2'd0;
            wcnt_q    <= '0;
            inta_n_q  <= 1'b1;
            valid_q   <= 1'b0;
            vector_q  <= 8'h00;
`ifdef INTA_MODE_8080_EN
            opcode_q  <= 8'h00;
            addr_hi_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            wcnt_q    <= wcnt_d;
            inta_n_q  <= inta_n_d;
            valid_q   <= valid_d;
            vector_q  <= vector_d;
`ifdef INTA_MODE_8080_EN
            opcode_q  <= opcode_d;
            addr_hi_q <= addr_hi_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        wcnt_d    = wcnt_q;
        inta_n_d  = inta_n_q;
        valid_d   = valid_q;
        vector_d  = vector_q;
`ifdef INTA_MODE_8080_EN
        opcode_d  = opcode_q;
        addr_hi_d = addr_hi_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (intr_s && int_en && !valid_q) begin
                    state_d  = StPulse;
                    pcnt_d   = 2'd0;
                    wcnt_d   = '0;
                    inta_n_d = 1'b0;
                end
            end
            StPulse: begin
                if (wcnt_q == LOW_LAST) begin
                    wcnt_d   = '0;
                    inta_n_d = 1'b1;
                    if (pcnt_q == LAST_PULSE) begin
                        state_d = StHold;
                        valid_d = 1'b1;
`ifdef INTA_MODE_8080_EN
                        addr_hi_d = data_in;
`else
                        vector_d  = data_in;
`endif
                    end else begin
                        state_d = StGap;
`ifdef INTA_MODE_8080_EN
                        // Pulse 1 carries the CALL opcode, pulse 2 the vector byte
                        if (pcnt_q == 2'd0) begin
                            opcode_d = data_in;
                        end else begin
                            vector_d = data_in;
                        end
`endif
                    end
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            StGap: begin
                if (wcnt_q == GAP_LAST) begin
                    wcnt_d   = '0;
                    pcnt_d   = pcnt_q + 2'd1;
                    state_d  = StPulse;
                    inta_n_d = 1'b0;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            StHold: begin
                if (vector_ack) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        inta_n       = inta_n_q;
        busy         = (state_q != StIdle);
        vector_valid = valid_q;
        vector       = vector_q;
`ifdef INTA_MODE_8080_EN
        call_addr    = {addr_hi_q, vector_q};
`else
        call_addr    = 16'h0000;
`endif
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with a small PIC data-bus model.
// Define INTA_MODE_8080_EN to exercise the 3-pulse CALL mode.
module tb_inta_sequencer;

`ifdef INTA_MODE_8080_EN
    localparam logic [1:0] NP        = 2'd3;
    localparam int         SEQ_EDGES = 10;
    localparam logic [9:0] PATTERN   = 10'b1001100110;
`else
    localparam logic [1:0] NP        = 2'd2;
    localparam int         SEQ_EDGES = 6;
    localparam logic [5:0] PATTERN   = 6'b100110;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        intr;
    logic        int_en;
    logic [7:0]  data_in;
    logic        inta_n;
    logic        busy;
    logic        vector_valid;
    logic [7:0]  vector;
    logic        vector_ack;
    logic [15:0] call_addr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pic_bytes [0:3];
    logic [1:0] pulse_no;

    inta_sequencer #(
        .INTA_LOW_CYCLES (2),
        .INTA_GAP_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .intr         (intr),
        .int_en       (int_en),
        .data_in      (data_in),
        .inta_n       (inta_n),
        .busy         (busy),
        .vector_valid (vector_valid),
        .vector       (vector),
        .vector_ack   (vector_ack),
        .call_addr    (call_addr)
    );

    always #5 clk = ~clk;

    // PIC model: counts INTA falls within a sequence and drives the matching byte while low
    always @(negedge inta_n or posedge reset) begin
        if (reset) pulse_no <= 2'd0;
        else       pulse_no <= (pulse_no == NP) ? 2'd1 : pulse_no + 2'd1;
    end

    assign data_in = (!inta_n) ? pic_bytes[pulse_no] : 8'hFF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_call(input logic [7:0] vec);
`ifdef INTA_MODE_8080_EN
        return {pic_bytes[3], vec};
`else
        return (vec == vec) ? 16'h0000 : 16'hFFFF;
`endif
    endfunction

    task automatic wait_fall(input string tag);
        int n;
        n = 0;
        while (inta_n !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, inta_n}, 32'd0);
    endtask

    // Called just after the edge on which inta_n fell; walks the full pulse train
    task automatic run_seq(input logic [7:0] vec, input int drop_at);
        logic [SEQ_EDGES-1:0] pat;
        pat = PATTERN;
        for (int i = 0; i < SEQ_EDGES; i++) begin
            tick();
            if (i == drop_at) intr = 1'b0;
            chk("inta_pattern", {31'd0, inta_n}, {31'd0, pat[i]});
            chk("valid_timing", {31'd0, vector_valid}, (i == SEQ_EDGES - 1) ? 32'd1 : 32'd0);
        end
        chk("vector", {24'd0, vector}, {24'd0, vec});
        chk("call_addr", {16'd0, call_addr}, {16'd0, exp_call(vec)});
        chk("busy_hold", {31'd0, busy}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        intr       = 1'b0;
        int_en     = 1'b0;
        vector_ack = 1'b0;
        pic_bytes[0] = 8'hFF;
`ifdef INTA_MODE_8080_EN
        pic_bytes[1] = 8'hCD;
        pic_bytes[3] = 8'h01;
`else
        pic_bytes[1] = 8'hFF;
        pic_bytes[3] = 8'hFF;
`endif
        pic_bytes[2] = 8'h48;
        tick();
        tick();
        chk("rst_inta_n", {31'd0, inta_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, vector_valid}, 32'd0);
        chk("rst_vector", {24'd0, vector}, 32'h00);
        chk("rst_call_addr", {16'd0, call_addr}, 32'h0000);
        reset = 1'b0;

        // Interrupts masked: nothing may start
        intr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("masked_inta_n", {31'd0, inta_n}, 32'd1);
            chk("masked_busy", {31'd0, busy}, 32'd0);
        end
        int_en = 1'b1;
        tick();
        chk("enable_start", {31'd0, inta_n}, 32'd0);
        chk("enable_busy", {31'd0, busy}, 32'd1);
        run_seq(8'h48, -1);

        // Backpressure: vector pending blocks further pulses
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_inta_n", {31'd0, inta_n}, 32'd1);
            chk("bp_valid", {31'd0, vector_valid}, 32'd1);
            chk("bp_vector", {24'd0, vector}, 32'h48);
        end
        vector_ack = 1'b1;
        tick();
        vector_ack = 1'b0;
        chk("ack_clears_valid", {31'd0, vector_valid}, 32'd0);
        chk("ack_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("back_to_back", {31'd0, inta_n}, 32'd0);

        // intr dropped during the gap: sequence still completes with the spurious vector
        pic_bytes[2] = 8'h3F;
        int_en = 1'b0;
        run_seq(8'h3F, 1);
        int_en = 1'b1;
        vector_ack = 1'b1;
        tick();
        vector_ack = 1'b0;
        chk("ack2_valid", {31'd0, vector_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_restart_inta_n", {31'd0, inta_n}, 32'd1);
            chk("no_restart_busy", {31'd0, busy}, 32'd0);
        end
        chk("vector_held", {24'd0, vector}, 32'h3F);

        // Reset during pulse 2
        pic_bytes[2] = 8'h55;
        intr = 1'b1;
        wait_fall("start_timeout");
        for (int i = 0; i < 4; i++) tick();
        chk("in_pulse2", {31'd0, inta_n}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_inta_n", {31'd0, inta_n}, 32'd1);
        chk("abort_valid", {31'd0, vector_valid}, 32'd0);
        chk("abort_vector", {24'd0, vector}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        pic_bytes[2] = 8'h66;
        wait_fall("restart_timeout");
        run_seq(8'h66, -1);

`ifdef INTA_MODE_8080_EN
        pic_bytes[2] = 8'h20;
        vector_ack = 1'b1;
        tick();
        vector_ack = 1'b0;
        tick();
        chk("mode8080_start", {31'd0, inta_n}, 32'd0);
        run_seq(8'h20, -1);
        chk("mode8080_call", {16'd0, call_addr}, 32'h0120);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-side counterpart of the PIC control logic: the initiator of the interrupt-acknowledge protocol.
- Watches the PIC's INT output, gated by the CPU interrupt-enable flag, and drives the active-low INTA pulse train (two pulses, 8086 mode).
- Captures the vector byte the PIC places on the data bus during the final pulse and presents it to the CPU core with a valid/ack handshake.
- Sits between the PIC instance and the CPU model in the system testbench/top.

Parameters:
- INTA_LOW_CYCLES, 2, clocks inta_n is held low per pulse; legal range >=1.
- INTA_GAP_CYCLES, 2, clocks inta_n is held high between pulses; legal range >=1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- intr  input  1  INT from PIC; asynchronous to clk, passes through a 2-flop synchronizer.
- int_en  input  1  CPU interrupt-enable flag (IF).
- data_in  input  8  PIC data bus, sampled during the INTA pulses.
- inta_n  output  1  interrupt acknowledge to the PIC, active low.
- busy  output  1  high whenever state != IDLE.
- vector_valid  output  1  captured vector available.
- vector  output  8  captured interrupt vector.
- vector_ack  input  1  CPU consumes the vector.
- call_addr  output  16  8080-mode CALL target; see Optional Feature.

Behaviour:
- Reset values: inta_n=1, busy=0, vector_valid=0, vector=8'h00, call_addr=16'h0000, state=IDLE, synchronizer flops=0.
- Reset asserted mid-sequence aborts the sequence. inta_n returns high asynchronously and no vector is produced.
- intr_s is the output of the second synchronizer flop. Latency from intr to intr_s is 2 edges.
- States: IDLE, PULSE, GAP, HOLD. A pulse counter (pcnt) tracks which pulse is active. A width counter (wcnt) is sized to fit max(INTA_LOW_CYCLES, INTA_GAP_CYCLES).
- IDLE: if intr_s && int_en && !vector_valid, go to PULSE with pcnt=0 and wcnt=0. inta_n goes low on that same edge.
- PULSE: inta_n=0. wcnt increments each clock.
  - When wcnt==INTA_LOW_CYCLES-1 and this is not the last pulse: go to GAP, clear wcnt, inta_n goes high.
  - When this is the last pulse: sample data_in on that edge into vector, set vector_valid=1, inta_n goes high, go to HOLD.
- GAP: inta_n=1. When wcnt==INTA_GAP_CYCLES-1: increment pcnt, go to PULSE.
- Pulse count: 8086 mode has 2 pulses. Pulse 1 data is ignored because the PIC drives nothing on it.
- HOLD: vector_valid=1 until vector_ack is sampled high. On that edge clear vector_valid and go to IDLE. vector holds its value until the next capture.
- Earliest restart: a new sequence can begin the cycle after ack, if intr_s is still high. This allows back-to-back interrupts.
- Latency: inta_n falls 1 edge after the qualifying IDLE cycle. vector_valid rises 2*INTA_LOW_CYCLES+INTA_GAP_CYCLES edges after inta_n falls. With defaults that is 6 edges.
- Once a sequence has started it always completes:
  - intr deasserting mid-sequence is ignored; the PIC supplies the spurious IR7 vector.
  - int_en changes mid-sequence are ignored.
- vector_ack while not in HOLD: ignored.
- intr_s high while vector_valid is pending: no new pulses are issued.
- inta_n is driven directly from a flop, never combinational, so it is glitch-free.

Optional Feature:
- Macro: INTA_MODE_8080_EN.
- Defined:
  - Three pulses per sequence.
  - Pulse 1 byte is captured. It is expected to be the CALL opcode 8'hCD; any other value still completes the sequence.
  - Pulse 2 byte goes to vector.
  - Pulse 3 byte goes to call_addr[15:8]; call_addr[7:0] = vector.
  - vector_valid latency becomes 3*INTA_LOW_CYCLES+2*INTA_GAP_CYCLES.
- Undefined: 2 pulses; call_addr is tied to 16'h0000.

Decomposition:
- Shared package pic_pkg holds:
  - the state encoding constants (IDLE/PULSE/GAP/HOLD);
  - CALL_OPCODE=8'hCD;
  - NUM_PULSES_8086=2 and NUM_PULSES_8080=3.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with asynchronous active-high reset, reusable for other async PIC-side inputs.

Test Plan:
- Defaults: int_en=1, raise intr; PIC model drives data_in=8'h48 during pulse 2.
  - Expect exactly 2 inta_n low pulses, each 2 cycles wide with a 2-cycle gap.
  - Expect vector=8'h48 and vector_valid high 6 edges after the first inta_n fall.
- int_en=0 with intr high for 20 cycles -> inta_n stays 1 and busy stays 0. Then set int_en=1 -> sequence starts within 1 edge.
- Backpressure: hold vector_ack=0 for 10 cycles with intr still high.
  - Expect no further inta_n pulses and vector stable at 8'h48.
  - Pulse vector_ack -> vector_valid clears and a new sequence begins the next cycle.
- Drop intr midway through the GAP state -> sequence completes. Expect vector=8'h3F, the spurious IR7 vector driven by the model.
- Assert reset during pulse 2 -> inta_n=1 immediately, vector_valid=0, vector=8'h00. After release with intr high, a fresh 2-pulse sequence runs.
- With INTA_MODE_8080_EN defined: PIC model drives 8'hCD, 8'h20, 8'h01.
  - Expect 3 pulses, vector=8'h20, call_addr=16'h0120.
  - Expect vector_valid 10 edges after the first fall.
